// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stalls, branch squashes,
// data-memory waits with a timeout watchdog. Optional stall/flush statistics: PIPE_STALL_STATS_EN.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        busy,
`ifdef PIPE_STALL_STATS_EN
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_events,
`endif
  output logic        mem_err
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             mem_err_reg, mem_err_next;

  logic load_use;
  logic mem_stall;
  logic mem_done;
  logic pipe_rules;

  assign load_use  = ex_memread & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
  // mem_ready only counts when there is an access outstanding
  assign mem_stall = mem_req & ~mem_ready;
  assign mem_done  = mem_req & mem_ready;

  always_comb begin
    pc_en         = 1'b0;
    ifid_en       = 1'b0;
    idex_en       = 1'b0;
    exmem_en      = 1'b0;
    memwb_en      = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    pipe_rules    = 1'b0;
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    mem_err_next  = mem_err_reg;

    case (state_reg)
      RUN: begin
        if (mem_stall) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = CNT_W'(1);
        end else begin
          pipe_rules = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_done) begin
          pipe_rules    = 1'b1;
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt_reg == CNT_W'(MEM_TIMEOUT)) begin
          state_next   = ERR;
          mem_err_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        end
      end
      ERR: begin
        mem_err_next = 1'b1;
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase

    // Branch squash beats load-use: the dependent load consumer is squashed anyway
    if (pipe_rules) begin
      if (ex_branch_taken) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        idex_flush = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
      end
    end

    // During reset every register loads, and the front two load bubbles
    if (!rst_n) begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
      mem_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      mem_err_reg  <= mem_err_next;
    end
  end

  assign busy    = rst_n & (state_reg != RUN);
  assign mem_err = mem_err_reg;

`ifdef PIPE_STALL_STATS_EN
  logic [31:0] stall_cycles_reg;
  logic [15:0] flush_events_reg;

  // Saturating counters; reset cycles never count as flushes
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      stall_cycles_reg <= '0;
      flush_events_reg <= '0;
    end else begin
      if (!pc_en && (stall_cycles_reg != '1))
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if ((ifid_flush | idex_flush) && (flush_events_reg != '1))
        flush_events_reg <= flush_events_reg + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign flush_events = flush_events_reg;
`endif

endmodule
